verificador_pin: RTL and testbench
==================================

VERIFICADOR_PIN -- requirements
Module: verificador_pin

Interface
REQ-001 SHALL have parameter TIMEOUT_CICLOS, default 16'd1000: idle cycles after a partial entry before that entry is discarded.
REQ-002 SHALL have parameter MAX_INTENTOS, default 3: failed attempts that cause lockout; legal range 2..7.
REQ-003 SHALL have port clk, input, 1: system clock; all state changes on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port digito_stb, input, 1: one-cycle strobe; digito is valid when high.
REQ-006 SHALL have port digito, input, 4: BCD digit, legal values 0..9.
REQ-007 SHALL have port pin_correcto, input, 16: stored PIN, 4 BCD digits, first digit in [15:12]; stable during operation.
REQ-008 SHALL have port pin_incorrecto, output, 1: one-cycle pulse on each failed attempt.
REQ-009 SHALL have port advertencia, output, 1: level; high when exactly one attempt remains before lockout.
REQ-010 SHALL have port bloqueo, output, 1: level; card locked until reset.
REQ-011 SHALL have port fin, output, 1: one-cycle pulse when the correct PIN is entered.

Function
REQ-012 SHALL implement states RECIBIENDO, VERIFICAR and BLOQUEADO, encoded as a registered state variable.
REQ-013 In RECIBIENDO, each sampled digito_stb with digito<=9 SHALL shift the digit into a 16-bit register, left-shift by 4 with the new digit in [3:0], and increment a 3-bit digit count.
REQ-014 A strobe with digito>9 SHALL be ignored: no shift, no count change, no attempt consumed, timeout not restarted.
REQ-015 The edge that samples the 4th valid digit SHALL move the state to VERIFICAR.
REQ-016 In VERIFICAR, one cycle: equal -> fin=1; unequal -> pin_incorrecto=1 and failure count +1; the state then returns to RECIBIENDO with the digit count cleared.
REQ-017 Consequence of REQ-015/016: a result pulse SHALL be visible in the cycle after the edge that sampled the 4th digit (latency 1 clock); pulses last exactly one cycle.
REQ-018 Strobes arriving while in VERIFICAR SHALL be ignored.
REQ-019 A correct PIN SHALL clear the failure count and deassert advertencia in the same edge that asserts fin.
REQ-020 advertencia SHALL be registered high when the failure count equals MAX_INTENTOS-1, and low otherwise.
REQ-021 On the failure that makes the count equal MAX_INTENTOS: pin_incorrecto SHALL pulse, bloqueo SHALL assert, advertencia SHALL deassert, and the state SHALL go to BLOQUEADO, all on that same edge.
REQ-022 In BLOQUEADO, all strobes SHALL be ignored, bloqueo SHALL stay high, fin and pin_incorrecto SHALL stay low, and only reset exits.
REQ-023 In RECIBIENDO with digit count 1..3, a 16-bit idle counter SHALL increment each cycle without a valid strobe and be cleared by each valid strobe.
REQ-024 When the idle counter reaches TIMEOUT_CICLOS-1, the partial entry SHALL be discarded (digit count and shift register cleared) with no attempt consumed and no output pulse.
REQ-025 Timeout and a valid strobe in the same cycle: the strobe SHALL win, the digit is accepted and the idle counter is cleared.
REQ-026 With digit count 0, the idle counter SHALL be held at 0 and no timeout SHALL occur.

Reset
REQ-027 reset low SHALL immediately set state=RECIBIENDO, shift register=0, digit count=0, failure count=0, idle counter=0, and pin_incorrecto=advertencia=bloqueo=fin=0, independent of clk.
REQ-028 Reset asserted mid-entry or in BLOQUEADO SHALL discard all progress, including lockout; the first strobe after release SHALL be treated as digit 1.
REQ-029 Release SHALL be synchronised so that no state change occurs on the first clock edge after reset deassertion.

Verification
REQ-030 pin_correcto=16'h1234, digits 1,2,3,4 -> fin high for one cycle, one cycle after the 4th strobe edge; other outputs 0.
REQ-031 Digits 1,2,3,5 twice with MAX_INTENTOS=3 -> two pin_incorrecto pulses, advertencia=1 after the 2nd; then 1,2,3,4 -> fin=1 and advertencia=0.
REQ-032 Three wrong PINs -> 3rd pin_incorrecto pulse coincident with bloqueo=1; then 1,2,3,4 -> no fin, bloqueo remains 1; reset low -> bloqueo=0.
REQ-033 Digits 1,2, then TIMEOUT_CICLOS idle cycles, then 1,2,3,4 -> fin=1 and no pin_incorrecto (partial entry discarded).
REQ-034 Sequence 1,0xA,2,3,4 -> fin=1 (0xA ignored); reset pulsed after digit 3 of an entry, then 1,2,3,4 -> fin=1.

Source files
------------

// File: rtl/verificador_pin.sv
// verificador_pin: 4-digit BCD PIN checker with retry counting, a warning
// when one attempt remains, lockout after MAX_INTENTOS failures, and
// discarding of partial entries after TIMEOUT_CICLOS idle cycles.
module verificador_pin #(
    parameter logic [15:0] TIMEOUT_CICLOS = 16'd1000,
    parameter int          MAX_INTENTOS   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        digito_stb,
    input  logic [3:0]  digito,
    input  logic [15:0] pin_correcto,
    output logic        pin_incorrecto,
    output logic        advertencia,
    output logic        bloqueo,
    output logic        fin
);

    typedef enum logic [1:0] {
        RECIBIENDO = 2'd0,
        VERIFICAR  = 2'd1,
        BLOQUEADO  = 2'd2
    } estado_t;

    localparam logic [2:0]  MAX_FALLOS = 3'(MAX_INTENTOS);
    localparam logic [2:0]  FALLOS_AVISO = 3'(MAX_INTENTOS - 1);
    localparam logic [15:0] IDLE_LIMITE = TIMEOUT_CICLOS - 16'd1;

    estado_t     estado_q, estado_d;
    logic [15:0] shift_q, shift_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  fallos_q, fallos_d;
    logic [15:0] idle_q, idle_d;
    logic        run_q, run_d;
    logic        pin_inc_q, pin_inc_d;
    logic        adv_q, adv_d;
    logic        bloq_q, bloq_d;
    logic        fin_q, fin_d;

    logic        valido;
    logic [15:0] nuevo;
    logic [2:0]  fallos_mas1;

    // Next-state logic: digit capture, verification, timeout and lockout.
    // run_q gates everything so the first edge after reset release is inert.
    always_comb begin
        estado_d    = estado_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        fallos_d    = fallos_q;
        idle_d      = idle_q;
        run_d       = 1'b1;
        pin_inc_d   = 1'b0;
        fin_d       = 1'b0;
        valido      = digito_stb && (digito <= 4'd9);
        nuevo       = {shift_q[11:0], digito};
        fallos_mas1 = fallos_q + 3'd1;

        if (run_q) begin
            case (estado_q)
                RECIBIENDO: begin
                    if (valido) begin
                        shift_d = nuevo;
                        idle_d  = 16'd0;
                        if (cnt_q == 3'd3) begin
                            // Result is registered on the sampling edge of the
                            // 4th digit so the pulse shows up one cycle later.
                            cnt_d = 3'd0;
                            if (nuevo == pin_correcto) begin
                                fin_d    = 1'b1;
                                fallos_d = 3'd0;
                                estado_d = VERIFICAR;
                            end else begin
                                pin_inc_d = 1'b1;
                                fallos_d  = fallos_mas1;
                                if (fallos_mas1 == MAX_FALLOS) begin
                                    estado_d = BLOQUEADO;
                                end else begin
                                    estado_d = VERIFICAR;
                                end
                            end
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end else if (cnt_q != 3'd0) begin
                        if (idle_q == IDLE_LIMITE) begin
                            cnt_d   = 3'd0;
                            shift_d = 16'd0;
                            idle_d  = 16'd0;
                        end else begin
                            idle_d = idle_q + 16'd1;
                        end
                    end else begin
                        idle_d = 16'd0;
                    end
                end
                VERIFICAR: begin
                    // One dead cycle while the result pulse is visible.
                    estado_d = RECIBIENDO;
                    cnt_d    = 3'd0;
                    shift_d  = 16'd0;
                    idle_d   = 16'd0;
                end
                BLOQUEADO: begin
                    estado_d = BLOQUEADO;
                end
                default: begin
                    estado_d = RECIBIENDO;
                end
            endcase
        end

        adv_d  = (estado_d != BLOQUEADO) && (fallos_d == FALLOS_AVISO);
        bloq_d = (estado_d == BLOQUEADO);
    end

    // State and registered outputs; asynchronous clear, synchronous release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q  <= RECIBIENDO;
            shift_q   <= 16'd0;
            cnt_q     <= 3'd0;
            fallos_q  <= 3'd0;
            idle_q    <= 16'd0;
            run_q     <= 1'b0;
            pin_inc_q <= 1'b0;
            adv_q     <= 1'b0;
            bloq_q    <= 1'b0;
            fin_q     <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            fallos_q  <= fallos_d;
            idle_q    <= idle_d;
            run_q     <= run_d;
            pin_inc_q <= pin_inc_d;
            adv_q     <= adv_d;
            bloq_q    <= bloq_d;
            fin_q     <= fin_d;
        end
    end

    assign pin_incorrecto = pin_inc_q;
    assign advertencia    = adv_q;
    assign bloqueo        = bloq_q;
    assign fin            = fin_q;

endmodule

// File: tb/tb_verificador_pin.sv
// Scoreboard bench for verificador_pin: a queue-based reference model predicts
// every fin/pin_incorrecto pulse and the advertencia/bloqueo levels.
module tb_verificador_pin;

    localparam logic [15:0] TO   = 16'd20;
    localparam int          MAXI = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        digito_stb = 1'b0;
    logic [3:0]  digito = 4'd0;
    logic [15:0] pin_correcto = 16'h1234;
    logic        pin_incorrecto, advertencia, bloqueo, fin;

    verificador_pin #(.TIMEOUT_CICLOS(TO), .MAX_INTENTOS(MAXI)) dut (
        .clk(clk), .reset(reset), .digito_stb(digito_stb), .digito(digito),
        .pin_correcto(pin_correcto), .pin_incorrecto(pin_incorrecto),
        .advertencia(advertencia), .bloqueo(bloqueo), .fin(fin)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int cyc;
        bit fin;
        bit adv;
        bit bloq;
    } ev_t;
    ev_t sb[$];

    // Reference model: digits entered so far, failures, lock, verify gap.
    int m_dig[$];
    int m_fails = 0;
    int m_idle = 0;
    bit m_locked = 0;
    bit m_busy = 0;
    bit m_dead = 0;

    function automatic bit m_adv();
        return (m_fails == MAXI - 1) && !m_locked;
    endfunction

    function automatic int bcd_val(input logic [15:0] p);
        return int'(p[15:12]) * 1000 + int'(p[11:8]) * 100 + int'(p[7:4]) * 10 + int'(p[3:0]);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // What the next rising edge does, in terms of the user-visible rules.
    task automatic model_step(input bit stb, input logic [3:0] d);
        ev_t e;
        int  val;
        if (m_dead) begin
            m_dead = 0;
            return;
        end
        if (m_locked) return;
        if (m_busy) begin
            m_busy = 0;
            return;
        end
        if (stb && d <= 4'd9) begin
            m_dig.push_back(int'(d));
            m_idle = 0;
            if (m_dig.size() == 4) begin
                val = m_dig[0] * 1000 + m_dig[1] * 100 + m_dig[2] * 10 + m_dig[3];
                e.cyc = cyc + 1;
                if (val == bcd_val(pin_correcto)) begin
                    m_fails = 0;
                    e.fin = 1;
                end else begin
                    m_fails++;
                    e.fin = 0;
                    if (m_fails == MAXI) m_locked = 1;
                end
                m_dig.delete();
                if (!m_locked) m_busy = 1;
                e.adv = m_adv();
                e.bloq = m_locked;
                sb.push_back(e);
            end
        end else if (m_dig.size() > 0) begin
            m_idle++;
            if (m_idle == int'(TO)) begin
                m_dig.delete();
                m_idle = 0;
            end
        end
    endtask

    task automatic tick(input bit stb, input logic [3:0] d);
        @(negedge clk);
        digito_stb = stb;
        digito = d;
        model_step(stb, d);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 4'($urandom_range(0, 15)));
    endtask

    task automatic enter(input logic [15:0] p);
        tick(1'b1, p[15:12]);
        tick(1'b1, p[11:8]);
        tick(1'b1, p[7:4]);
        tick(1'b1, p[3:0]);
        tick(1'b0, 4'd0);
    endtask

    task automatic do_reset(input logic [15:0] new_pin);
        @(negedge clk);
        reset = 1'b0;
        digito_stb = 1'b0;
        m_dig.delete();
        m_fails = 0;
        m_idle = 0;
        m_locked = 0;
        m_busy = 0;
        m_dead = 0;
        #1;
        chk("rst_fin", fin, 0);
        chk("rst_pin_incorrecto", pin_incorrecto, 0);
        chk("rst_advertencia", advertencia, 0);
        chk("rst_bloqueo", bloqueo, 0);
        pin_correcto = new_pin;
        repeat (2) @(negedge clk);
        // Release with a strobe already present: that edge must not take it.
        reset = 1'b1;
        m_dead = 1;
        digito_stb = 1'b1;
        digito = 4'($urandom_range(0, 9));
        model_step(1'b1, digito);
    endtask

    function automatic logic [15:0] rand_pin();
        return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
    endfunction

    // Monitor: compare levels every cycle and pop one expectation per pulse.
    initial begin
        ev_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            chk("advertencia", advertencia, m_adv());
            chk("bloqueo", bloqueo, m_locked);
            if (fin || pin_incorrecto) begin
                if (sb.size() == 0) begin
                    chk("pulso_inesperado", {fin, pin_incorrecto}, 0);
                end else begin
                    e = sb.pop_front();
                    chk("ciclo_pulso", cyc, e.cyc);
                    chk("fin", fin, e.fin);
                    chk("pin_incorrecto", pin_incorrecto, !e.fin);
                    chk("advertencia_pulso", advertencia, e.adv);
                    chk("bloqueo_pulso", bloqueo, e.bloq);
                end
            end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                chk("pulso_ausente", {fin, pin_incorrecto}, sb[0].fin ? 2 : 1);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        int r;
        do_reset(16'h1234);
        // Correct PIN.
        enter(16'h1234);
        idle(3);
        // Two wrong, warning, then correct clears it.
        enter(16'h1235);
        enter(16'h1235);
        idle(2);
        enter(16'h1234);
        idle(2);
        // Lockout, entries ignored while locked, reset clears it.
        enter(16'h9999);
        enter(16'h1235);
        enter(16'h0000);
        enter(16'h1234);
        idle(3);
        do_reset(16'h1234);
        idle(2);
        // Timeout boundary: TO-1 idle cycles keep the entry, TO discard it.
        tick(1'b1, 4'd1); tick(1'b1, 4'd2);
        idle(int'(TO) - 1);
        tick(1'b1, 4'd3); tick(1'b1, 4'd4); tick(1'b0, 4'd0);
        idle(2);
        tick(1'b1, 4'd1); tick(1'b1, 4'd2);
        idle(int'(TO));
        enter(16'h1234);
        idle(2);
        // Illegal digit ignored, strobe during verify ignored.
        tick(1'b1, 4'd1); tick(1'b1, 4'hA); tick(1'b1, 4'd2);
        tick(1'b1, 4'd3); tick(1'b1, 4'd4); tick(1'b1, 4'd1);
        idle(2);
        // Reset mid-entry.
        tick(1'b1, 4'd1); tick(1'b1, 4'd2); tick(1'b1, 4'd3);
        do_reset(16'h1234);
        enter(16'h1234);
        idle(2);
        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 3 || (m_locked && r < 12)) begin
                do_reset(rand_pin());
            end else if (r < 18) begin
                enter(pin_correcto);
            end else if (r < 30) begin
                enter(pin_correcto ^ (16'h1 << (4 * $urandom_range(0, 3))));
            end else if (r < 38) begin
                idle(int'(TO) - 2 + $urandom_range(0, 3));
            end else if (r < 46) begin
                tick(1'b1, 4'($urandom_range(10, 15)));
            end else if (r < 80) begin
                tick(1'b1, 4'($urandom_range(0, 9)));
            end else begin
                tick(1'b0, 4'd0);
            end
        end
        idle(5);
        chk("cola_vacia", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
